// File: rtl/dcache_ctrl.sv
// Data-cache controller: same-cycle hit resolution against an async-read SRAM
// array. On a miss it stalls the CPU, writes back a dirty victim, fetches the
// missing block, refills the array and then replays the held request.
module dcache_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int BLOCK_BYTES = 16,
  parameter int SET_INDEX_W = 6,
  parameter int CNT_W       = 16,
  localparam int OFFSET_W   = $clog2(BLOCK_BYTES),
  localparam int TAG_W      = ADDR_W - OFFSET_W - SET_INDEX_W,
  localparam int BLK_W      = ADDR_W - OFFSET_W,
  localparam int DATA_W     = 8 * BLOCK_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_ren,
  input  logic                   cpu_wen,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [31:0]            cpu_wdata,
  input  logic [3:0]             cpu_bytes,
  output logic [31:0]            cpu_rdata,
  output logic                   cpu_stall,
  output logic                   sram_ren,
  output logic                   sram_wen,
  output logic                   sram_memWen,
  output logic [BLOCK_BYTES-1:0] sram_bytesAccess,
  output logic [BLK_W-1:0]       sram_blockAddr,
  output logic [DATA_W-1:0]      sram_dataIn,
  input  logic                   sram_hit,
  input  logic                   sram_dirty,
  input  logic [DATA_W-1:0]      sram_dataOut,
  input  logic [TAG_W-1:0]       victim_tag,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [BLK_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ready,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic [CNT_W-1:0]       miss_cnt,
  output logic [CNT_W-1:0]       wb_cnt
);

  typedef enum logic [1:0] {IDLE, WB, FILL, REFILL} state_e;

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   blk_addr_q, blk_addr_d;
  logic [TAG_W-1:0]   victim_tag_q, victim_tag_d;
  logic [DATA_W-1:0]  wb_buf_q, wb_buf_d;
  logic [DATA_W-1:0]  fill_buf_q, fill_buf_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]   wb_cnt_q, wb_cnt_d;

  // Request decode. Byte offset of the addressed word, and its bit offset.
  logic                req, is_store, miss;
  logic [OFFSET_W-1:0] woff;
  logic [OFFSET_W+2:0] bitoff;
  logic                unused_addr_lsb;

  assign req             = cpu_ren | cpu_wen;
  assign is_store        = cpu_wen;   // ren & wen together behaves as a store
  assign miss            = req & ~sram_hit;
  assign woff            = {cpu_addr[OFFSET_W-1:2], 2'b00};
  assign bitoff          = {woff, 3'b000};
  assign unused_addr_lsb = ^cpu_addr[1:0];

  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;

  // State and latched miss context; reset abandons any memory transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      blk_addr_q   <= '0;
      victim_tag_q <= '0;
      wb_buf_q     <= '0;
      fill_buf_q   <= '0;
      miss_cnt_q   <= '0;
      wb_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      blk_addr_q   <= blk_addr_d;
      victim_tag_q <= victim_tag_d;
      wb_buf_q     <= wb_buf_d;
      fill_buf_q   <= fill_buf_d;
      miss_cnt_q   <= miss_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
    end
  end

  // Next state: capture the miss in IDLE, then walk WB -> FILL -> REFILL.
  always_comb begin
    state_d      = state_q;
    blk_addr_d   = blk_addr_q;
    victim_tag_d = victim_tag_q;
    wb_buf_d     = wb_buf_q;
    fill_buf_d   = fill_buf_q;
    miss_cnt_d   = miss_cnt_q;
    wb_cnt_d     = wb_cnt_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          blk_addr_d   = cpu_addr[ADDR_W-1:OFFSET_W];
          wb_buf_d     = sram_dataOut;
          victim_tag_d = victim_tag;
          miss_cnt_d   = miss_cnt_q + CNT_W'(1);
          state_d      = sram_dirty ? WB : FILL;
        end
      end
      WB: begin
        if (mem_ready) begin
          wb_cnt_d = wb_cnt_q + CNT_W'(1);
          state_d  = FILL;
        end
      end
      FILL: begin
        if (mem_ready) begin
          fill_buf_d = mem_rdata;
          state_d    = REFILL;
        end
      end
      REFILL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: array/CPU side in IDLE, memory side in WB/FILL; all zero in reset.
  always_comb begin
    cpu_rdata        = '0;
    cpu_stall        = 1'b0;
    sram_ren         = 1'b0;
    sram_wen         = 1'b0;
    sram_memWen      = 1'b0;
    sram_bytesAccess = '0;
    sram_blockAddr   = '0;
    sram_dataIn      = '0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          sram_blockAddr = cpu_addr[ADDR_W-1:OFFSET_W];
          if (is_store) begin
            sram_wen         = 1'b1;
            sram_bytesAccess = BLOCK_BYTES'(cpu_bytes) << woff;
            sram_dataIn      = {(BLOCK_BYTES/4){cpu_wdata}};
          end else if (cpu_ren) begin
            sram_ren = 1'b1;
          end
          if (sram_hit) cpu_rdata = sram_dataOut[bitoff +: 32];
          cpu_stall = miss;
        end
        WB: begin
          sram_blockAddr = blk_addr_q;
          cpu_stall      = 1'b1;
          mem_req        = 1'b1;
          mem_we         = 1'b1;
          mem_addr       = {victim_tag_q, blk_addr_q[SET_INDEX_W-1:0]};
          mem_wdata      = wb_buf_q;
        end
        FILL: begin
          sram_blockAddr = blk_addr_q;
          cpu_stall      = 1'b1;
          mem_req        = 1'b1;
          mem_addr       = blk_addr_q;
        end
        REFILL: begin
          sram_blockAddr = blk_addr_q;
          sram_memWen    = 1'b1;
          sram_dataIn    = fill_buf_q;
          cpu_stall      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a direct-mapped SRAM array model.
module tb_dcache_ctrl;
  localparam int ADDR_W = 32, BB = 16, SIW = 6, CNT_W = 16;
  localparam int TAG_W = 22, BLK_W = 28, DW = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_ren, cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_bytes;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              sram_ren, sram_wen, sram_memWen;
  logic [BB-1:0]     sram_bytesAccess;
  logic [BLK_W-1:0]  sram_blockAddr;
  logic [DW-1:0]     sram_dataIn;
  logic              sram_hit, sram_dirty;
  logic [DW-1:0]     sram_dataOut;
  logic [TAG_W-1:0]  victim_tag;
  logic              mem_req, mem_we;
  logic [BLK_W-1:0]  mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_ready;
  logic [DW-1:0]     mem_rdata;
  logic [CNT_W-1:0]  miss_cnt, wb_cnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dcache_ctrl #(.ADDR_W(ADDR_W), .BLOCK_BYTES(BB), .SET_INDEX_W(SIW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_bytes(cpu_bytes),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_memWen(sram_memWen),
    .sram_bytesAccess(sram_bytesAccess), .sram_blockAddr(sram_blockAddr),
    .sram_dataIn(sram_dataIn), .sram_hit(sram_hit), .sram_dirty(sram_dirty),
    .sram_dataOut(sram_dataOut), .victim_tag(victim_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
  );

  // Direct-mapped array model: async read / hit, sync write and refill.
  bit   [63:0]      m_valid;
  bit   [63:0]      m_dirty;
  logic [TAG_W-1:0] m_tag  [64];
  logic [DW-1:0]    m_data [64];
  logic [5:0]       m_idx;
  logic [TAG_W-1:0] m_atag;

  assign m_idx        = sram_blockAddr[5:0];
  assign m_atag       = sram_blockAddr[BLK_W-1:6];
  assign sram_hit     = m_valid[m_idx] && (m_tag[m_idx] === m_atag);
  assign sram_dirty   = m_dirty[m_idx];
  assign sram_dataOut = m_valid[m_idx] ? m_data[m_idx] : '0;
  assign victim_tag   = m_valid[m_idx] ? m_tag[m_idx] : '0;

  always @(posedge clk) begin
    logic [DW-1:0] t;
    if (sram_memWen) begin
      m_data[m_idx]  <= sram_dataIn;
      m_tag[m_idx]   <= m_atag;
      m_valid[m_idx] <= 1'b1;
      m_dirty[m_idx] <= 1'b0;
    end else if (sram_wen && sram_hit) begin
      t = m_data[m_idx];
      for (int b = 0; b < BB; b++)
        if (sram_bytesAccess[b]) t[8*b +: 8] = sram_dataIn[8*b +: 8];
      m_data[m_idx]  <= t;
      m_dirty[m_idx] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [DW-1:0] B1   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [DW-1:0] B1M  = 128'h0F0E0D0C_0B0ACCDD_07060504_03020100;
  localparam logic [DW-1:0] B2   = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
  localparam logic [DW-1:0] B3   = 128'h2F2E2D2C_2B2A2928_27262524_23222120;

  initial begin
    rst = 1'b0; cpu_ren = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h40;
    cpu_wdata = '0; cpu_bytes = '0; mem_ready = 1'b0; mem_rdata = '0;
    #2;
    chk("rst_stall",   cpu_stall, 0);
    chk("rst_sramren", sram_ren, 0);
    chk("rst_memreq",  mem_req, 0);
    chk("rst_misscnt", miss_cnt, 0);
    chk("rst_wbcnt",   wb_cnt, 0);

    // Cold load of 0x40: clean miss.
    step(); rst = 1'b1; #2;
    chk("cold_stall",  cpu_stall, 1);
    chk("cold_ren",    sram_ren, 1);
    chk("cold_noreq",  mem_req, 0);
    step(); #2;
    chk("fill_req",    mem_req, 1);
    chk("fill_we",     mem_we, 0);
    chk("fill_addr",   mem_addr, 28'h004);
    chk("fill_miss",   miss_cnt, 1);
    chk("fill_sramen", {sram_ren, sram_wen, sram_memWen}, 3'b000);
    step(); #2;
    chk("fill_hold",   mem_req, 1);
    step(); mem_ready = 1'b1; mem_rdata = B1; #2;
    chk("fill3_addr",  mem_addr, 28'h004);
    step(); mem_ready = 1'b0; #2;
    chk("refill_wen",  {sram_ren, sram_wen, sram_memWen}, 3'b001);
    chk("refill_data", sram_dataIn, B1);
    chk("refill_addr", sram_blockAddr, 28'h004);
    chk("refill_stl",  cpu_stall, 1);
    chk("refill_req",  mem_req, 0);
    step(); #2;
    chk("replay_stl",  cpu_stall, 0);
    chk("replay_data", cpu_rdata, 32'h03020100);
    chk("replay_miss", miss_cnt, 1);
    chk("replay_wb",   wb_cnt, 0);

    // Load hit 0x44.
    step(); cpu_addr = 32'h44; #2;
    chk("hit44_stl",   cpu_stall, 0);
    chk("hit44_data",  cpu_rdata, 32'h07060504);
    chk("hit44_req",   mem_req, 0);

    // Store hit 0x48, low two bytes.
    step(); cpu_ren = 1'b0; cpu_wen = 1'b1; cpu_addr = 32'h48;
    cpu_wdata = 32'hAABBCCDD; cpu_bytes = 4'b0011; #2;
    chk("st_bytes",    sram_bytesAccess, 16'h0300);
    chk("st_stl",      cpu_stall, 0);
    chk("st_ctl",      {sram_ren, sram_wen, sram_memWen}, 3'b010);
    chk("st_data",     sram_dataIn, {4{32'hAABBCCDD}});
    step(); cpu_wen = 1'b0; cpu_ren = 1'b1; #2;
    chk("ld48_data",   cpu_rdata, 32'h0B0ACCDD);

    // Conflict miss at 0x440 evicts the dirty line; 1-cycle transactions.
    step(); cpu_addr = 32'h440; #2;
    chk("cf_stl",      cpu_stall, 1);
    step(); mem_ready = 1'b1; #2;
    chk("wb_req",      mem_req, 1);
    chk("wb_we",       mem_we, 1);
    chk("wb_addr",     mem_addr, 28'h004);
    chk("wb_data",     mem_wdata, B1M);
    chk("wb_cnt0",     wb_cnt, 0);
    step(); mem_rdata = B2; #2;
    chk("cf_fill_we",  mem_we, 0);
    chk("cf_fill_ad",  mem_addr, 28'h044);
    chk("cf_wbcnt",    wb_cnt, 1);
    chk("cf_miss",     miss_cnt, 2);
    step(); mem_ready = 1'b0; #2;
    chk("cf_refill",   sram_dataIn, B2);
    step(); #2;
    chk("cf_replay",   cpu_rdata, 32'h13121110);
    chk("cf_rstl",     cpu_stall, 0);

    // Stray mem_ready in IDLE is ignored.
    step(); cpu_ren = 1'b0; mem_ready = 1'b1; #2;
    chk("idle_rdy_req", mem_req, 0);
    step(); mem_ready = 1'b0; cpu_ren = 1'b1; cpu_wen = 1'b1; cpu_bytes = 4'b0000; #2;
    chk("idle_rdy_stl", cpu_stall, 0);
    chk("idle_rdy_mc",  miss_cnt, 2);
    chk("rw_ctl",       {sram_ren, sram_wen, sram_memWen}, 3'b010);

    // Reset during FILL with mem_ready low.
    step(); cpu_wen = 1'b0; cpu_addr = 32'h880; #2;
    chk("r_miss_stl",  cpu_stall, 1);
    step(); #2;
    chk("r_fill_req",  mem_req, 1);
    chk("r_fill_addr", mem_addr, 28'h088);
    rst = 1'b0; #1;
    chk("r_req0",      mem_req, 0);
    chk("r_stl0",      cpu_stall, 0);
    chk("r_mc0",       miss_cnt, 0);
    chk("r_wc0",       wb_cnt, 0);
    step(); rst = 1'b1; #2;
    chk("r2_stl",      cpu_stall, 1);
    chk("r2_noreq",    mem_req, 0);
    step(); mem_ready = 1'b1; mem_rdata = B3; #2;
    chk("r2_fill_ad",  mem_addr, 28'h088);
    chk("r2_miss",     miss_cnt, 1);
    step(); mem_ready = 1'b0; #2;
    chk("r2_refill",   sram_memWen, 1);
    step(); #2;
    chk("r2_replay",   cpu_rdata, 32'h23222120);
    chk("r2_rstl",     cpu_stall, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
